// File: rtl/apu_req_issuer.sv
// rtl/apu_req_issuer.sv - core-side APU initiator with credit-bounded response FIFO
//
// Purpose: accepts FP operations from the core, issues them as APU requests
// (req/gnt with ID tag), collects APU responses into a registered FIFO and
// returns them to the core. A credit counter (cnt) limits granted-but-unpopped
// operations so every legal response always has FIFO space.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   op_*_i / op_ready_o        core operation port (valid/ready)
//   apu_req_o / apu_gnt_i      APU request handshake
//   apu_ID_o, apu_operands_o,
//   apu_op_o, apu_flags_o      registered request payload and tag
//   apu_rready_o               always 1
//   apu_r*_i                   APU response (valid, data, flags, ID)
//   res_*                      response FIFO head to the core (valid/ready)
//   credits_used_o             ops granted but not yet popped by the core
//   resp_err_o                 sticky: response arrived with nothing in flight
module apu_req_issuer #(
   parameter int ID_WIDTH        = 9,
   parameter int NB_ARGS         = 2,
   parameter int OPCODE_WIDTH    = 6,
   parameter int DATA_WIDTH      = 32,
   parameter int FLAGS_IN_WIDTH  = 15,
   parameter int FLAGS_OUT_WIDTH = 5,
   parameter int MAX_OUTSTANDING = 4,
   localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          op_valid_i,
   output logic                          op_ready_o,
   input  logic [NB_ARGS*DATA_WIDTH-1:0] op_operands_i,
   input  logic [OPCODE_WIDTH-1:0]       op_op_i,
   input  logic [FLAGS_IN_WIDTH-1:0]     op_flags_i,
   output logic                          apu_req_o,
   input  logic                          apu_gnt_i,
   output logic [ID_WIDTH-1:0]           apu_ID_o,
   output logic [NB_ARGS*DATA_WIDTH-1:0] apu_operands_o,
   output logic [OPCODE_WIDTH-1:0]       apu_op_o,
   output logic [FLAGS_IN_WIDTH-1:0]     apu_flags_o,
   output logic                          apu_rready_o,
   input  logic                          apu_rvalid_i,
   input  logic [DATA_WIDTH-1:0]         apu_rdata_i,
   input  logic [FLAGS_OUT_WIDTH-1:0]    apu_rflags_i,
   input  logic [ID_WIDTH-1:0]           apu_rID_i,
   output logic                          res_valid_o,
   input  logic                          res_ready_i,
   output logic [DATA_WIDTH-1:0]         res_data_o,
   output logic [FLAGS_OUT_WIDTH-1:0]    res_flags_o,
   output logic [ID_WIDTH-1:0]           res_id_o,
   output logic [CW-1:0]                 credits_used_o,
   output logic                          resp_err_o
);

   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam logic [CW:0] MAX_C = (CW+1)'(MAX_OUTSTANDING);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t                          state_q, state_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic [CW-1:0]                   fcnt_q, fcnt_d;
   logic [ID_WIDTH-1:0]             idc_q;
   logic [ID_WIDTH-1:0]             id_q;
   logic [NB_ARGS*DATA_WIDTH-1:0]   ops_q;
   logic [OPCODE_WIDTH-1:0]         op_q;
   logic [FLAGS_IN_WIDTH-1:0]       flags_q;
   logic                            err_q;
   logic [PW-1:0]                   wptr_q, rptr_q;
   logic [DATA_WIDTH-1:0]           mem_data  [MAX_OUTSTANDING];
   logic [FLAGS_OUT_WIDTH-1:0]      mem_flags [MAX_OUTSTANDING];
   logic [ID_WIDTH-1:0]             mem_id    [MAX_OUTSTANDING];

   logic        pend;
   logic [CW:0] committed;
   logic        accept, grant, pop, push, push_err;

   assign pend = (state_q == REQ);

   // Credits count both granted ops and the one sitting in the request
   // register, so a response slot is reserved before the op is even issued.
   assign committed  = {1'b0, cnt_q} + {{CW{1'b0}}, pend};
   assign op_ready_o = !rst && (!pend || apu_gnt_i) && (committed < MAX_C);

   assign accept   = op_valid_i && op_ready_o;
   assign grant    = pend && apu_gnt_i;
   assign res_valid_o = (fcnt_q != '0);
   assign pop      = res_valid_o && res_ready_i;
   // fcnt < cnt means some granted op still owes a response; this also
   // rules out any push into a full FIFO.
   assign push     = apu_rvalid_i && (fcnt_q < cnt_q);
   assign push_err = apu_rvalid_i && !(fcnt_q < cnt_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      apu_req_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = REQ;
         end
         REQ: begin
            apu_req_o = 1'b1;
            // A grant with a same-cycle accept keeps REQ with fresh payload.
            if (!accept && apu_gnt_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({grant, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      fcnt_d = fcnt_q;
      case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + CW'(1);
         2'b01:   fcnt_d = fcnt_q - CW'(1);
         default: fcnt_d = fcnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         fcnt_q  <= '0;
         idc_q   <= '0;
         id_q    <= '0;
         ops_q   <= '0;
         op_q    <= '0;
         flags_q <= '0;
         err_q   <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         fcnt_q <= fcnt_d;
         if (accept) begin
            ops_q   <= op_operands_i;
            op_q    <= op_op_i;
            flags_q <= op_flags_i;
            id_q    <= idc_q;
            idc_q   <= idc_q + ID_WIDTH'(1);
         end
         if (push_err) err_q  <= 1'b1;
         if (push)     wptr_q <= wptr_q + PW'(1);
         if (pop)      rptr_q <= rptr_q + PW'(1);
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wptr_q]  <= apu_rdata_i;
         mem_flags[wptr_q] <= apu_rflags_i;
         mem_id[wptr_q]    <= apu_rID_i;
      end
   end

   assign apu_ID_o       = id_q;
   assign apu_operands_o = ops_q;
   assign apu_op_o       = op_q;
   assign apu_flags_o    = flags_q;
   assign apu_rready_o   = 1'b1;
   assign res_data_o     = res_valid_o ? mem_data[rptr_q]  : '0;
   assign res_flags_o    = res_valid_o ? mem_flags[rptr_q] : '0;
   assign res_id_o       = res_valid_o ? mem_id[rptr_q]    : '0;
   assign credits_used_o = cnt_q;
   assign resp_err_o     = err_q;

endmodule
